lbuf_pingpong: RTL and testbench
================================

Name: lbuf_pingpong

Overview:
- Parametrised double-buffered line buffer, successor to the object-processor line buffer.
- Two banks alternate roles: one is the write side (object-processor pixel writes, plain or saturating read-modify-write); the other is the display side (video readout, with optional clear-to-background).
- Adds configurable width and depth, a pipelined RMW path with hazard forwarding, and a handshaked bank swap.

Parameters:
- DATA_W, 32, word width; must be a multiple of 16 (NLANE = DATA_W/16).
- ADDR_W, 9, address width; DEPTH = 2**ADDR_W words per bank.

Ports:
- sys_clk  in  1  single clock; all state is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_ready  out  1  write accepted when wr_en & wr_ready.
- wr_addr  in  ADDR_W  write-side word address.
- wr_data  in  DATA_W  write data, or signed delta when RMW.
- wr_be  in  DATA_W/8  byte enables.
- wr_rmw  in  1  1 = saturating add, 0 = plain write.
- rd_en  in  1  display-side read request; always accepted.
- rd_addr  in  ADDR_W  display-side word address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data valid.
- swap_req  in  1  request bank role swap (level or pulse).
- swap_ack  out  1  one-cycle pulse when the swap completes.
- wr_bank  out  1  bank currently on the write side; the display side is ~wr_bank.
- clr_en  in  1  clear display words after reading (LBUF_CLEAR_EN only).
- bg_color  in  16  background value, replicated to all lanes (LBUF_CLEAR_EN only).

Behaviour:
- Each bank is 1R1W synchronous RAM. RAM contents are not reset.
- Reset values: wr_bank=0, wr_ready=1, rd_valid=0, rd_data=0, swap_ack=0, FSM=IDLE, write pipeline flushed. Reset mid-swap aborts the swap with no ack and no toggle.
- Write pipeline (3 stages, fixed latency for both modes):
  - S0 (cycle N): accept the request and issue the RAM read.
  - S1 (N+1): RAM data returns; merge the forwarded operand; compute the result.
  - S2 (N+2): RAM write under wr_be.
  - Plain writes also traverse all stages to keep ordering.
- Forwarding: an RMW operand must reflect every earlier accepted write to the same address. Compare against the S1 and S2 entries per byte lane; the younger entry wins; disabled lanes fall through to the RAM data. Back-to-back RMW to one address every cycle must accumulate exactly.
- Saturating add, per 16-bit lane, unsigned base b plus signed delta d. Fields are [7:0] (8-bit), [11:8] (4-bit), [15:12] (4-bit):
  - sum = {0,b_f} + d_f.
  - If carry XOR msb(d_f), the field saturates to all copies of carry (all-ones on overflow, zero on underflow).
  - Otherwise the field is sum[f].
- Readout:
  - rd_en at cycle N reads bank ~wr_bank (sampled at N).
  - rd_data and rd_valid appear at N+1. rd_valid is low otherwise; rd_data holds its last value.
- Swap FSM:
  - IDLE: swap_req -> DRAIN. A write presented in the same cycle is still accepted.
  - DRAIN: wr_ready=0 until S0..S2 are empty, then -> FLIP.
  - FLIP: toggle wr_bank, pulse swap_ack, -> IDLE.
  - swap_req while in DRAIN or FLIP is absorbed; it does not queue a second swap.
  - A read issued before FLIP returns data from the old display bank.
- Reads and writes never touch the same bank, so there is no read/write arbitration.

Optional Feature:
- LBUF_CLEAR_EN defined:
  - A read at N with clr_en=1 writes {NLANE{bg_color}} to the same display-bank address at N+1 through the display bank's write port.
  - Reading the same address at N+1 returns the pre-clear data; a read at N+2 or later returns background.
  - No stall.
- Undefined: clr_en and bg_color are ignored, the display bank is never written, and no clear logic is generated.

Test Plan:
- Reset, then plain write 0x12345678 to addr 5 (all be), swap, read addr 5 -> swap_ack one cycle after the drain; rd_data=0x12345678 at N+1 with rd_valid=1.
- Base 0x00F0 in lane 0; RMW deltas 0x0020, then 0x0020 on consecutive cycles to the same addr -> low field saturates to 0xFF; upper fields unchanged; result 0x00FF.
- Base 0x0305; RMW delta 0x00FA (i.e. -6 in the low field) -> low field underflows to 0x00; result 0x0300.
- wr_be=4'b0011 write 0xAAAA_BBBB over 0x1111_2222 -> 0x1111_BBBB.
- swap_req while 3 writes are in flight -> wr_ready=0 for up to 3 cycles; all 3 writes land in the old write bank; then swap_ack and wr_bank toggles.
- LBUF_CLEAR_EN: bg_color=0x0088, clr_en=1, read addr 7 (0xDEADBEEF) -> returns 0xDEADBEEF; a re-read at N+2 returns 0x00880088.

Source files
------------

// File: rtl/lbuf_pingpong.sv
// lbuf_pingpong: double-buffered line buffer with two banks that swap roles.
//
// Purpose:
//   One bank is the write side. It takes object-processor pixel writes, either
//   plain writes or saturating read-modify-write adds. The other bank is the
//   display side and serves video readout. A handshaked swap drains the write
//   pipeline and then exchanges the two roles.
//
// Optional feature (compile-time macro LBUF_CLEAR_EN):
//   When defined, a display read with i_clr_en=1 writes the replicated
//   background colour back to the same address one cycle later. When undefined,
//   i_clr_en and i_bg_color are ignored and no clear logic is generated.
//
// Ports:
//   i_sys_clk    clock; all state updates on its rising edge
//   i_reset      synchronous active-high reset
//   i_wr_en      write request; accepted when i_wr_en & o_wr_ready
//   o_wr_ready   write side can accept a request
//   i_wr_addr    write-side word address
//   i_wr_data    write data, or per-lane signed deltas when i_wr_rmw=1
//   i_wr_be      byte enables
//   i_wr_rmw     1 = saturating add, 0 = plain write
//   i_rd_en      display read request (always accepted)
//   i_rd_addr    display-side word address
//   o_rd_data    read data, one cycle after i_rd_en; holds otherwise
//   o_rd_valid   o_rd_data carries fresh read data
//   i_swap_req   request a bank role swap
//   o_swap_ack   one-cycle pulse when the swap takes effect
//   o_wr_bank    bank currently on the write side
//   i_clr_en     clear-after-read enable (LBUF_CLEAR_EN only)
//   i_bg_color   16-bit background colour (LBUF_CLEAR_EN only)

module lbuf_pingpong #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    output logic                  o_wr_ready,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_wr_be,
    input  logic                  i_wr_rmw,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_swap_req,
    output logic                  o_swap_ack,
    output logic                  o_wr_bank,
    input  logic                  i_clr_en,
    input  logic [15:0]           i_bg_color
);

    localparam int unsigned NLANE = DATA_W / 16;
    localparam int unsigned NBYTE = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StDrain, StFlip} state_e;

    // Per 16-bit lane: unsigned base plus signed delta. Each field is
    // [7:0], [11:8] or [15:12], and each saturates independently.
    function automatic logic [15:0] f_sat_lane(input logic [15:0] b, input logic [15:0] d);
        logic [8:0]  s_lo;
        logic [4:0]  s_mid;
        logic [4:0]  s_hi;
        logic [15:0] r;
        s_lo    = {1'b0, b[7:0]}   + {1'b0, d[7:0]};
        s_mid   = {1'b0, b[11:8]}  + {1'b0, d[11:8]};
        s_hi    = {1'b0, b[15:12]} + {1'b0, d[15:12]};
        // If the carry disagrees with the delta sign, the field has left its
        // range. It clamps to all-ones on overflow and to zero on underflow.
        r[7:0]   = (s_lo[8]  ^ d[7])  ? {8{s_lo[8]}}  : s_lo[7:0];
        r[11:8]  = (s_mid[4] ^ d[11]) ? {4{s_mid[4]}} : s_mid[3:0];
        r[15:12] = (s_hi[4]  ^ d[15]) ? {4{s_hi[4]}}  : s_hi[3:0];
        return r;
    endfunction

    logic [DATA_W-1:0] r_mem0 [DEPTH];
    logic [DATA_W-1:0] r_mem1 [DEPTH];

    state_e            r_state;
    state_e            w_state_next;
    logic              r_wr_bank;
    logic              w_accept;

    // S1: RAM data has returned; the result is computed this cycle.
    logic              r_s1_vld;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [DATA_W-1:0] r_s1_data;
    logic [NBYTE-1:0]  r_s1_be;
    logic              r_s1_rmw;
    logic [NBYTE-1:0]  r_s1_fwd_mask;
    logic [DATA_W-1:0] r_s1_fwd_data;
    logic [DATA_W-1:0] r_ram_q;

    // S2: the merged word is written to RAM.
    logic              r_s2_vld;
    logic [ADDR_W-1:0] r_s2_addr;
    logic [DATA_W-1:0] r_s2_data;
    logic [NBYTE-1:0]  r_s2_be;

    logic [NBYTE-1:0]  w_fwd_mask;
    logic [DATA_W-1:0] w_fwd_data;
    logic [DATA_W-1:0] w_s1_oper;
    logic [DATA_W-1:0] w_s1_calc;
    logic [DATA_W-1:0] w_s1_result;

    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    assign w_accept = i_wr_en & o_wr_ready;

    // ---------------------------------------------------------------- swap FSM
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_wr_bank <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StFlip) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_swap_req) w_state_next = StDrain;
            // With S1 empty, any S2 entry retires at this edge. The pipeline
            // is therefore empty when FLIP begins.
            StDrain: if (!r_s1_vld) w_state_next = StFlip;
            StFlip:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign o_wr_ready = (r_state == StIdle);
    assign o_swap_ack = (r_state == StFlip);
    assign o_wr_bank  = r_wr_bank;

    // ------------------------------------------------------- write pipeline S0
    // The RAM read for this request misses two older writes: the S2 write
    // landing at this edge, and the S1 entry still being computed. Their
    // bytes are captured here; S1 is applied last so the younger entry wins.
    always_comb begin
        w_fwd_mask = '0;
        w_fwd_data = '0;
        for (int i = 0; i < int'(NBYTE); i++) begin
            if (r_s2_vld && (r_s2_addr == i_wr_addr) && r_s2_be[i]) begin
                w_fwd_mask[i]         = 1'b1;
                w_fwd_data[8*i +: 8]  = r_s2_data[8*i +: 8];
            end
            if (r_s1_vld && (r_s1_addr == i_wr_addr) && r_s1_be[i]) begin
                w_fwd_mask[i]         = 1'b1;
                w_fwd_data[8*i +: 8]  = w_s1_result[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            r_s2_vld <= r_s1_vld;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (w_accept) begin
            r_s1_addr     <= i_wr_addr;
            r_s1_data     <= i_wr_data;
            r_s1_be       <= i_wr_be;
            r_s1_rmw      <= i_wr_rmw;
            r_s1_fwd_mask <= w_fwd_mask;
            r_s1_fwd_data <= w_fwd_data;
            r_ram_q       <= r_wr_bank ? r_mem1[i_wr_addr] : r_mem0[i_wr_addr];
        end
        r_s2_addr <= r_s1_addr;
        r_s2_data <= w_s1_result;
        r_s2_be   <= r_s1_be;
    end

    // ------------------------------------------------------- write pipeline S1
    always_comb begin
        w_s1_oper = r_ram_q;
        for (int i = 0; i < int'(NBYTE); i++) begin
            if (r_s1_fwd_mask[i]) begin
                w_s1_oper[8*i +: 8] = r_s1_fwd_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_s1_calc = r_s1_data;
        if (r_s1_rmw) begin
            for (int l = 0; l < int'(NLANE); l++) begin
                w_s1_calc[16*l +: 16] = f_sat_lane(w_s1_oper[16*l +: 16], r_s1_data[16*l +: 16]);
            end
        end
    end

    // Disabled bytes carry the current operand. The S2 forward therefore
    // presents a whole, up-to-date word.
    always_comb begin
        w_s1_result = w_s1_oper;
        for (int i = 0; i < int'(NBYTE); i++) begin
            if (r_s1_be[i]) begin
                w_s1_result[8*i +: 8] = w_s1_calc[8*i +: 8];
            end
        end
    end

    // ---------------------------------------------------------- display clear
`ifdef LBUF_CLEAR_EN
    logic              r_clr_vld;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_clr_bank;
    logic [15:0]       r_clr_bg;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_clr_vld <= 1'b0;
        end else begin
            r_clr_vld <= i_rd_en & i_clr_en;
        end
        r_clr_addr <= i_rd_addr;
        r_clr_bank <= ~r_wr_bank;
        r_clr_bg   <= i_bg_color;
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = i_clr_en ^ (^i_bg_color);
`endif

    // ------------------------------------------------------------ RAM writes
    // During an S2 write the bank cannot change: a swap flips only once the
    // pipeline is empty.
    always_ff @(posedge i_sys_clk) begin
        if (!i_reset && r_s2_vld) begin
            for (int i = 0; i < int'(NBYTE); i++) begin
                if (r_s2_be[i]) begin
                    if (r_wr_bank) begin
                        r_mem1[r_s2_addr][8*i +: 8] <= r_s2_data[8*i +: 8];
                    end else begin
                        r_mem0[r_s2_addr][8*i +: 8] <= r_s2_data[8*i +: 8];
                    end
                end
            end
        end
`ifdef LBUF_CLEAR_EN
        if (!i_reset && r_clr_vld) begin
            if (r_clr_bank) begin
                r_mem1[r_clr_addr] <= {NLANE{r_clr_bg}};
            end else begin
                r_mem0[r_clr_addr] <= {NLANE{r_clr_bg}};
            end
        end
`endif
    end

    // ---------------------------------------------------------------- readout
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= r_wr_bank ? r_mem0[i_rd_addr] : r_mem1[i_rd_addr];
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_lbuf_pingpong.sv
// Self-checking bench for lbuf_pingpong (default parameters).
// A transaction-level model applies each accepted write at once, in program
// order. Swap timing comes from request and last-write times. A per-cycle
// compare process checks the DUT against this model. Directed literal checks
// pin the model itself.

module tb_lbuf_pingpong;

    localparam int AW = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic        wr_ready;
    logic [AW-1:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_rmw;
    logic        rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        swap_req;
    logic        swap_ack;
    logic        wr_bank;
    logic        clr_en;
    logic [15:0] bg_color;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    lbuf_pingpong #(.DATA_W(32), .ADDR_W(AW)) dut (
        .i_sys_clk  (clk),
        .i_reset    (reset),
        .i_wr_en    (wr_en),
        .o_wr_ready (wr_ready),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_wr_be    (wr_be),
        .i_wr_rmw   (wr_rmw),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .i_swap_req (swap_req),
        .o_swap_ack (swap_ack),
        .o_wr_bank  (wr_bank),
        .i_clr_en   (clr_en),
        .i_bg_color (bg_color)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    function automatic int clampi(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    function automatic logic [15:0] lane_add(input logic [15:0] b, input logic [15:0] d);
        int dlo, dmid, dhi, lo, mid, hi;
        logic [15:0] r;
        dlo  = d[7]  ? int'(d[7:0])   - 256 : int'(d[7:0]);
        dmid = d[11] ? int'(d[11:8])  - 16  : int'(d[11:8]);
        dhi  = d[15] ? int'(d[15:12]) - 16  : int'(d[15:12]);
        lo   = clampi(int'(b[7:0])   + dlo,  255);
        mid  = clampi(int'(b[11:8])  + dmid, 15);
        hi   = clampi(int'(b[15:12]) + dhi,  15);
        r[7:0]   = lo[7:0];
        r[11:8]  = mid[3:0];
        r[15:12] = hi[3:0];
        return r;
    endfunction

    function automatic logic [31:0] model_write(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] be, input logic rmw);
        logic [31:0] nv;
        logic [31:0] res;
        nv  = rmw ? {lane_add(old[31:16], d[31:16]), lane_add(old[15:0], d[15:0])} : d;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = nv[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0] m_mem [2][512];
    bit          m_known [2][512];
    bit          m_live = 1'b0;
    bit          m_pending;
    bit          m_bank;
    bit          m_valid;
    bit          m_rd_known;
    logic [31:0] m_rd_data;
    int          cyc = 0;
    int          m_ack_cyc;
    int          m_last_acc;
    bit          m_clr_pend;
    bit          m_clr_bank;
    logic [AW-1:0] m_clr_addr;
    logic [15:0] m_clr_bg;

    always @(posedge clk) begin
        bit idle;
        if (reset) begin
            m_live     = 1'b1;
            m_pending  = 1'b0;
            m_bank     = 1'b0;
            m_valid    = 1'b0;
            m_rd_data  = '0;
            m_rd_known = 1'b1;
            m_last_acc = -100;
            m_clr_pend = 1'b0;
        end else begin
            idle = !m_pending;
            if (wr_en && idle) begin
                m_mem[m_bank][wr_addr] = model_write(m_mem[m_bank][wr_addr], wr_data, wr_be, wr_rmw);
                if (!wr_rmw && wr_be == 4'hF) m_known[m_bank][wr_addr] = 1'b1;
                m_last_acc = cyc;
            end
            if (idle && swap_req) begin
                m_pending = 1'b1;
                // Ack once the last accepted write has landed; never earlier than 2 cycles.
                m_ack_cyc = (cyc + 2 > m_last_acc + 3) ? cyc + 2 : m_last_acc + 3;
            end
            m_valid = rd_en;
            if (rd_en) begin
                m_rd_data  = m_mem[!m_bank][rd_addr];
                m_rd_known = m_known[!m_bank][rd_addr];
            end
`ifdef LBUF_CLEAR_EN
            if (m_clr_pend) begin
                m_mem[m_clr_bank][m_clr_addr]   = {m_clr_bg, m_clr_bg};
                m_known[m_clr_bank][m_clr_addr] = 1'b1;
            end
            m_clr_pend = rd_en && clr_en;
            m_clr_bank = !m_bank;
            m_clr_addr = rd_addr;
            m_clr_bg   = bg_color;
`endif
            if (m_pending && cyc == m_ack_cyc) begin
                m_bank    = !m_bank;
                m_pending = 1'b0;
            end
        end
        cyc++;
    end

    // ---------------------------------------------------------- compare
    always @(negedge clk) begin
        if (m_live) begin
            chk("wr_ready", 32'(wr_ready), 32'(!m_pending));
            chk("swap_ack", 32'(swap_ack), 32'(m_pending && cyc == m_ack_cyc));
            chk("wr_bank", 32'(wr_bank), 32'(m_bank));
            chk("rd_valid", 32'(rd_valid), 32'(m_valid));
            if (m_rd_known) chk("rd_data", rd_data, m_rd_data);
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic rmw);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be; wr_rmw = rmw;
        @(negedge clk);
        wr_en = 1'b0; wr_rmw = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic c);
        rd_en = 1'b1; rd_addr = a; clr_en = c;
        @(negedge clk);
        rd_en = 1'b0; clr_en = 1'b0;
    endtask

    // Call at the negedge right after the swap request cycle.
    task automatic swap_wait(input bit do_rd, input logic [AW-1:0] a,
                             output int low, output int ack_at, output bit seen);
        low = 0; ack_at = -1; seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!wr_ready) low++;
            if (swap_ack && !seen) begin seen = 1'b1; ack_at = i; end
            if (seen && wr_ready) break;
            rd_en = do_rd; rd_addr = a;
            @(negedge clk);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        int low, ack_at;
        bit seen;
        logic [31:0] exp_clr;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; wr_rmw = 1'b0;
        rd_en = 1'b0; rd_addr = '0; swap_req = 1'b0; clr_en = 1'b0; bg_color = 16'h0088;
        repeat (2) @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_wr_bank", 32'(wr_bank), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_swap_ack", 32'(swap_ack), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Plain write, swap, read back from the new display bank.
        wr(9'd5, 32'h12345678, 4'hF, 1'b0);
        swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;
        swap_wait(1'b0, 9'd0, low, ack_at, seen);
        chk("swap1_seen", 32'(seen), 32'd1);
        chk("swap1_ack_delay", 32'(ack_at), 32'd1);
        chk("swap1_bank", 32'(wr_bank), 32'd1);
        rd(9'd5, 1'b0);
        chk("t1_rd_data", rd_data, 32'h12345678);
        chk("t1_rd_valid", 32'(rd_valid), 32'd1);

        // Back-to-back writes into bank 1 exercise S1/S2 forwarding.
        wr(9'd10, 32'h000000F0, 4'hF, 1'b0);
        wr(9'd10, 32'h00000020, 4'hF, 1'b1);
        wr(9'd10, 32'h00000020, 4'hF, 1'b1);
        wr(9'd11, 32'h00000305, 4'hF, 1'b0);
        wr(9'd11, 32'h000000FA, 4'hF, 1'b1);
        wr(9'd12, 32'h11112222, 4'hF, 1'b0);
        wr(9'd12, 32'hAAAABBBB, 4'b0011, 1'b0);
        wr(9'd13, 32'h12340000, 4'hF, 1'b0);
        wr(9'd13, 32'hF0FF0000, 4'hF, 1'b1);
        wr(9'd7,  32'hDEADBEEF, 4'hF, 1'b0);
        wr(9'd30, 32'h00000010, 4'hF, 1'b0);
        wr(9'd31, 32'h00000000, 4'hF, 1'b0);
        wr(9'd30, 32'h00010001, 4'hF, 1'b1);
        wr(9'd31, 32'h0F010F01, 4'b1100, 1'b1);

        // Swap while three writes are in flight; reads during the drain hit bank 0.
        wr(9'd20, 32'hA0A0A0A0, 4'hF, 1'b0);
        wr(9'd21, 32'h0B0B0B0B, 4'hF, 1'b0);
        wr_en = 1'b1; wr_addr = 9'd22; wr_data = 32'h00C000C0; wr_be = 4'hF; swap_req = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; swap_req = 1'b0;
        swap_wait(1'b1, 9'd5, low, ack_at, seen);
        chk("swap2_seen", 32'(seen), 32'd1);
        chk("swap2_ready_low", 32'(low), 32'd3);
        chk("swap2_bank", 32'(wr_bank), 32'd0);

        rd(9'd10, 1'b0); chk("sat_overflow", rd_data, 32'h000000FF);
        rd(9'd11, 1'b0); chk("sat_underflow", rd_data, 32'h00000300);
        rd(9'd12, 1'b0); chk("byte_enable", rd_data, 32'h1111BBBB);
        rd(9'd13, 1'b0); chk("rmw_fields", rd_data, 32'h02330000);
        rd(9'd30, 1'b0); chk("fwd_s2", rd_data, 32'h00010011);
        rd(9'd31, 1'b0); chk("fwd_s2_partial", rd_data, 32'h00010000);
        rd(9'd20, 1'b0); chk("inflight_20", rd_data, 32'hA0A0A0A0);
        rd(9'd21, 1'b0); chk("inflight_21", rd_data, 32'h0B0B0B0B);
        rd(9'd22, 1'b0); chk("inflight_22", rd_data, 32'h00C000C0);

        // Clear-after-read: the next-cycle re-read still sees the old data.
`ifdef LBUF_CLEAR_EN
        exp_clr = 32'h00880088;
`else
        exp_clr = 32'hDEADBEEF;
`endif
        rd(9'd7, 1'b1); chk("clr_first", rd_data, 32'hDEADBEEF);
        rd(9'd7, 1'b0); chk("clr_n1", rd_data, 32'hDEADBEEF);
        rd(9'd7, 1'b0); chk("clr_n2", rd_data, exp_clr);
        repeat (2) @(negedge clk);
        chk("rd_hold", rd_data, exp_clr);

        // Reset during DRAIN aborts the swap.
        swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (swap_ack) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_ack", 32'(seen), 32'd0);
        chk("abort_bank", 32'(wr_bank), 32'd0);
        chk("abort_ready", 32'(wr_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
